// File: rtl/commutation_pkg.sv
// Shared types, widths and hall-code constants for the BLDC commutation controller.
// Also holds the commutation table and per-phase drive encoding as functions.
package commutation_pkg;

  localparam int PWM_W = 11;

  typedef enum logic [1:0] {
    HIGH_Z  = 2'b00,
    FORWARD = 2'b01,
    REVERSE = 2'b10,
    BRAKE   = 2'b11
  } phase_drv_t;

  // Hall codes are {Grn,Ylw,Blu}
  localparam logic [2:0] HALL_UV  = 3'b101;
  localparam logic [2:0] HALL_UW  = 3'b100;
  localparam logic [2:0] HALL_VW  = 3'b110;
  localparam logic [2:0] HALL_VU  = 3'b010;
  localparam logic [2:0] HALL_WU  = 3'b011;
  localparam logic [2:0] HALL_WV  = 3'b001;
  localparam logic [2:0] HALL_LOW = 3'b000;
  localparam logic [2:0] HALL_HIGH = 3'b111;

  localparam logic [1:0] PH_U    = 2'd0;
  localparam logic [1:0] PH_V    = 2'd1;
  localparam logic [1:0] PH_W    = 2'd2;
  localparam logic [1:0] PH_NONE = 2'd3;

  function automatic logic hall_invalid(input logic [2:0] code);
    return (code == HALL_LOW) || (code == HALL_HIGH);
  endfunction

  function automatic phase_drv_t table_mode(input logic [2:0] code, input logic [1:0] phase);
    logic [1:0] hi_ph;
    logic [1:0] lo_ph;
    case (code)
      HALL_UV: begin hi_ph = PH_U; lo_ph = PH_V; end
      HALL_UW: begin hi_ph = PH_U; lo_ph = PH_W; end
      HALL_VW: begin hi_ph = PH_V; lo_ph = PH_W; end
      HALL_VU: begin hi_ph = PH_V; lo_ph = PH_U; end
      HALL_WU: begin hi_ph = PH_W; lo_ph = PH_U; end
      HALL_WV: begin hi_ph = PH_W; lo_ph = PH_V; end
      default: begin hi_ph = PH_NONE; lo_ph = PH_NONE; end
    endcase
    if (phase == hi_ph) begin
      return FORWARD;
    end else if (phase == lo_ph) begin
      return REVERSE;
    end else begin
      return HIGH_Z;
    end
  endfunction

  // Returns {high, low}; high and low are never both set for any mode.
  function automatic logic [1:0] drive_bits(input phase_drv_t mode, input logic pwm);
    case (mode)
      FORWARD: return {pwm, ~pwm};
      REVERSE: return {~pwm, pwm};
      BRAKE:   return {1'b0, pwm};
      HIGH_Z:  return 2'b00;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/commutation_ctrl_if.sv
// Hall, drive-command and FET-request signal bundle of the commutation controller.
// slave is the controller side, master is the side that drives halls and commands.
interface commutation_ctrl_if #(
  parameter int PWM_W = commutation_pkg::PWM_W
) ();
  logic             hallGrn;
  logic             hallYlw;
  logic             hallBlu;
  logic [PWM_W-1:0] drv_mag;
  logic             enable;
  logic             brake_n;
  logic             highU;
  logic             lowU;
  logic             highV;
  logic             lowV;
  logic             highW;
  logic             lowW;
  logic             PWM_synch;
  logic [2:0]       rotation_state;
  logic             fault;

  modport master (
    output hallGrn, hallYlw, hallBlu, drv_mag, enable, brake_n,
    input  highU, lowU, highV, lowV, highW, lowW, PWM_synch, rotation_state, fault
  );

  modport slave (
    input  hallGrn, hallYlw, hallBlu, drv_mag, enable, brake_n,
    output highU, lowU, highV, lowV, highW, lowW, PWM_synch, rotation_state, fault
  );
endinterface

// File: rtl/commutation_ctrl_pwm_gen.sv
// Free-running PWM counter with per-period duty sample, compare and period-start pulse.
// The first period starts in the first clock cycle after reset release.
module pwm_gen #(
  parameter int PWM_W = commutation_pkg::PWM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] drv_mag,
  output logic             pwm,
  output logic             pwm_synch
);

  localparam logic [PWM_W-1:0] CNT_ZERO = {PWM_W{1'b0}};
  localparam logic [PWM_W-1:0] CNT_ONE  = {{(PWM_W-1){1'b0}}, 1'b1};

  logic             run_r;
  logic [PWM_W-1:0] cnt_r;
  logic [PWM_W-1:0] duty_r;
  logic             synch_r;
  logic [PWM_W-1:0] cnt_nxt_s;
  logic [PWM_W-1:0] duty_s;

  // Next count and effective duty; in the count==0 cycle the live command is used
  always_comb begin
    cnt_nxt_s = cnt_r;
    duty_s    = duty_r;
    if (run_r) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
    if (cnt_r == CNT_ZERO) begin
      duty_s = drv_mag;
    end else begin
      duty_s = duty_r;
    end
  end

  // Counter, duty sample and period-start pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r   <= 1'b0;
      cnt_r   <= CNT_ZERO;
      duty_r  <= CNT_ZERO;
      synch_r <= 1'b0;
    end else begin
      run_r   <= 1'b1;
      cnt_r   <= cnt_nxt_s;
      synch_r <= (cnt_nxt_s == CNT_ZERO);
      if (run_r && (cnt_r == CNT_ZERO)) begin
        duty_r <= drv_mag;
      end else begin
        duty_r <= duty_r;
      end
    end
  end

  assign pwm       = (cnt_r < duty_s);
  assign pwm_synch = synch_r;

endmodule

// File: rtl/commutation_ctrl.sv
// Six-step BLDC commutation: synchronized and filtered halls, period-latched rotor
// state, and registered per-phase FET requests under enable/brake/fault priority.
module commutation_ctrl #(
  parameter int HALL_FILT = 8,
  parameter int PWM_W     = commutation_pkg::PWM_W
) (
  input logic              clk,
  input logic              rst_n,
  commutation_ctrl_if.slave bus
);
  import commutation_pkg::*;

  localparam int              CW       = $clog2(HALL_FILT + 1);
  localparam logic [CW-1:0]   FILT_MAX = CW'(HALL_FILT);
  localparam logic [CW-1:0]   FILT_ACC = CW'(HALL_FILT - 1);
  localparam logic [CW-1:0]   FILT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [2:0]    sync1_r;
  logic [2:0]    sync2_r;
  logic [2:0]    cand_r;
  logic [CW-1:0] filt_cnt_r;
  logic [2:0]    acc_r;
  logic [2:0]    rot_r;
  logic          fault_r;
  logic [5:0]    drv_r;
  logic [5:0]    drv_s;
  phase_drv_t    mode_s;
  logic          pwm_s;
  logic          synch_s;

  // Two-flop synchronizer on the raw hall levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
    end else begin
      sync1_r <= {bus.hallGrn, bus.hallYlw, bus.hallBlu};
      sync2_r <= sync1_r;
    end
  end

  // Hold filter: a code is accepted once it has been stable HALL_FILT cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_r     <= 3'b000;
      filt_cnt_r <= {CW{1'b0}};
      acc_r      <= 3'b000;
    end else if (sync2_r != cand_r) begin
      cand_r     <= sync2_r;
      filt_cnt_r <= {CW{1'b0}};
    end else begin
      if (filt_cnt_r < FILT_MAX) begin
        filt_cnt_r <= filt_cnt_r + FILT_ONE;
      end else begin
        filt_cnt_r <= filt_cnt_r;
      end
      if (filt_cnt_r >= FILT_ACC) begin
        acc_r <= cand_r;
      end else begin
        acc_r <= acc_r;
      end
    end
  end

  pwm_gen #(.PWM_W(PWM_W)) u_pwm_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .drv_mag   (bus.drv_mag),
    .pwm       (pwm_s),
    .pwm_synch (synch_s)
  );

  // Rotor state and fault only move at a period start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_r   <= 3'b000;
      fault_r <= 1'b0;
    end else if (synch_s) begin
      rot_r   <= acc_r;
      fault_r <= hall_invalid(acc_r);
    end else begin
      rot_r   <= rot_r;
      fault_r <= fault_r;
    end
  end

  // Per-phase mode selection and {high,low} encoding; bits [2p+1:2p] belong to phase p
  always_comb begin
    drv_s  = 6'b000000;
    mode_s = HIGH_Z;
    for (int p = 0; p < 3; p++) begin
      if (!bus.enable) begin
        mode_s = HIGH_Z;
      end else if (!bus.brake_n) begin
        mode_s = BRAKE;
      end else if (fault_r) begin
        mode_s = HIGH_Z;
      end else begin
        mode_s = table_mode(rot_r, 2'(p));
      end
      drv_s[2*p +: 2] = drive_bits(mode_s, pwm_s);
    end
  end

  // Registered FET requests; both bits come from one pwm sample so they never overlap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_r <= 6'b000000;
    end else begin
      drv_r <= drv_s;
    end
  end

  assign bus.highU          = drv_r[1];
  assign bus.lowU           = drv_r[0];
  assign bus.highV          = drv_r[3];
  assign bus.lowV           = drv_r[2];
  assign bus.highW          = drv_r[5];
  assign bus.lowW           = drv_r[4];
  assign bus.PWM_synch      = synch_s;
  assign bus.rotation_state = rot_r;
  assign bus.fault          = fault_r;

endmodule

// File: tb/tb_commutation_ctrl.sv
// Directed bench for commutation_ctrl: per-period high-cycle counts against a vector
// table, plus hand sequences for latch timing, glitch rejection, fault recovery and reset.
module tb_commutation_ctrl;

  localparam int P = 2048;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   overlap_cnt;
  int   meas [6];

  commutation_ctrl_if #(.PWM_W(11)) bus ();

  commutation_ctrl #(.HALL_FILT(8), .PWM_W(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [2:0]  hall;
    logic        en;
    logic        brk_n;
    logic [10:0] duty;
    int          settle;
    logic [2:0]  rot;
    logic        flt;
    int          cnt [6];
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(input logic [2:0] h, input logic e, input logic b,
                              input logic [10:0] d, input int st, input logic [2:0] r,
                              input logic f, input int hu, input int lu, input int hv,
                              input int lv, input int hw, input int lw);
    vec_t v;
    v.hall = h; v.en = e; v.brk_n = b; v.duty = d; v.settle = st; v.rot = r; v.flt = f;
    v.cnt[0] = hu; v.cnt[1] = lu; v.cnt[2] = hv; v.cnt[3] = lv; v.cnt[4] = hw; v.cnt[5] = lw;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_hall(input logic [2:0] h);
    bus.hallGrn = h[2];
    bus.hallYlw = h[1];
    bus.hallBlu = h[0];
  endtask

  task automatic wait_synch();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.PWM_synch && n < 3000);
    if (!bus.PWM_synch) begin
      checks++;
      errors++;
      $display("FAIL wait_synch: PWM_synch not seen within %0d cycles", n);
    end
  endtask

  function automatic logic [10:0] all_outs();
    return {bus.highU, bus.lowU, bus.highV, bus.lowV, bus.highW, bus.lowW,
            bus.PWM_synch, bus.rotation_state, bus.fault};
  endfunction

  // Shoot-through watchdog over the whole run, reset included
  always @(negedge clk) begin
    if ((bus.highU && bus.lowU) || (bus.highV && bus.lowV) || (bus.highW && bus.lowW)) begin
      overlap_cnt++;
      $display("FAIL overlap at %0t: U=%b%b V=%b%b W=%b%b", $time,
               bus.highU, bus.lowU, bus.highV, bus.lowV, bus.highW, bus.lowW);
    end
  end

  initial begin
    int   acc;
    errors      = 0;
    checks      = 0;
    overlap_cnt = 0;

    vecs[0] = mk(3'b101, 1'b1, 1'b1, 11'd1024, 2, 3'd5, 1'b0, 1024, 1024, 1024, 1024, 0, 0);
    vecs[1] = mk(3'b100, 1'b1, 1'b1, 11'd512,  2, 3'd4, 1'b0, 512, 1536, 0, 0, 1536, 512);
    vecs[2] = mk(3'b110, 1'b1, 1'b1, 11'd300,  2, 3'd6, 1'b0, 0, 0, 300, 1748, 1748, 300);
    vecs[3] = mk(3'b010, 1'b1, 1'b1, 11'd2047, 2, 3'd2, 1'b0, 1, 2047, 2047, 1, 0, 0);
    vecs[4] = mk(3'b011, 1'b1, 1'b1, 11'd0,    2, 3'd3, 1'b0, 2048, 0, 0, 0, 0, 2048);
    vecs[5] = mk(3'b001, 1'b1, 1'b1, 11'd100,  2, 3'd1, 1'b0, 0, 0, 1948, 100, 100, 1948);
    vecs[6] = mk(3'b111, 1'b1, 1'b1, 11'd1024, 2, 3'd7, 1'b1, 0, 0, 0, 0, 0, 0);
    vecs[7] = mk(3'b101, 1'b1, 1'b0, 11'd0,    2, 3'd5, 1'b0, 0, 0, 0, 0, 0, 0);
    vecs[8] = mk(3'b101, 1'b1, 1'b0, 11'd2047, 1, 3'd5, 1'b0, 0, 2047, 0, 2047, 0, 2047);
    vecs[9] = mk(3'b101, 1'b0, 1'b0, 11'd2047, 1, 3'd5, 1'b0, 0, 0, 0, 0, 0, 0);

    // Power-on reset
    rst_n = 1'b0;
    set_hall(3'b101);
    bus.drv_mag = 11'd1024;
    bus.enable  = 1'b1;
    bus.brake_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", {21'd0, all_outs()}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_synch_por", {31'd0, bus.PWM_synch}, 32'd1);

    // Table: settle, then count high cycles of each output over one full period
    for (int i = 0; i < 10; i++) begin
      set_hall(vecs[i].hall);
      bus.enable  = vecs[i].en;
      bus.brake_n = vecs[i].brk_n;
      bus.drv_mag = vecs[i].duty;
      repeat (16) @(negedge clk);
      for (int s = 0; s < vecs[i].settle; s++) wait_synch();
      for (int k = 0; k < 6; k++) meas[k] = 0;
      for (int c = 0; c < P; c++) begin
        @(negedge clk);
        meas[0] += int'(bus.highU); meas[1] += int'(bus.lowU);
        meas[2] += int'(bus.highV); meas[3] += int'(bus.lowV);
        meas[4] += int'(bus.highW); meas[5] += int'(bus.lowW);
      end
      chk($sformatf("v%0d_rot", i), {29'd0, bus.rotation_state}, {29'd0, vecs[i].rot});
      chk($sformatf("v%0d_fault", i), {31'd0, bus.fault}, {31'd0, vecs[i].flt});
      for (int k = 0; k < 6; k++)
        chk($sformatf("v%0d_out%0d_count", i, k), meas[k], vecs[i].cnt[k]);
    end

    // Invalid code latched, then recovery at the next period start
    bus.enable  = 1'b1;
    bus.brake_n = 1'b1;
    bus.drv_mag = 11'd1024;
    set_hall(3'b111);
    repeat (16) @(negedge clk);
    wait_synch();
    wait_synch();
    acc = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      acc += int'(bus.highU | bus.lowU | bus.highV | bus.lowV | bus.highW | bus.lowW);
    end
    chk("fault_set", {31'd0, bus.fault}, 32'd1);
    chk("fault_outs_zero", acc, 0);
    set_hall(3'b101);
    repeat (16) @(negedge clk);
    chk("fault_hold_mid", {31'd0, bus.fault}, 32'd1);
    wait_synch();
    chk("fault_hold_synch", {31'd0, bus.fault}, 32'd1);
    @(negedge clk);
    chk("fault_clear", {31'd0, bus.fault}, 32'd0);
    chk("fault_clear_rot", {29'd0, bus.rotation_state}, 32'd5);

    // Hall step: rotation_state follows only after the next period start
    set_hall(3'b100);
    repeat (100) @(negedge clk);
    chk("step_rot_mid", {29'd0, bus.rotation_state}, 32'd5);
    wait_synch();
    chk("step_rot_synch", {29'd0, bus.rotation_state}, 32'd5);
    @(negedge clk);
    chk("step_rot_after", {29'd0, bus.rotation_state}, 32'd4);

    // 5-cycle glitch placed so its synchronized copy straddles PWM_synch
    repeat (2043) @(negedge clk);
    set_hall(3'b101);
    repeat (5) @(negedge clk);
    set_hall(3'b100);
    repeat (20) @(negedge clk);
    chk("glitch_rot_a", {29'd0, bus.rotation_state}, 32'd4);
    wait_synch();
    @(negedge clk);
    chk("glitch_rot_b", {29'd0, bus.rotation_state}, 32'd4);

    // Reset mid-period
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {21'd0, all_outs()}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_held", {21'd0, all_outs()}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_synch_mid", {31'd0, bus.PWM_synch}, 32'd1);
    @(negedge clk);
    chk("synch_one_cycle", {31'd0, bus.PWM_synch}, 32'd0);
    repeat (300) @(negedge clk);
    chk("no_overlap", overlap_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
